// File: rtl/sram_arbiter_if.sv
// Requester-side bus for one sram_arbiter port: level request held until a 1-cycle ack.
// Latency: none (wires only). Backpressure: the requester holds req and its fields stable until ack.
// The master modport is the requester; the slave modport is the arbiter.
interface sram_arbiter_if #(
    parameter int ADDR_W = 18
);
    logic              req;
    logic              we;
    logic [1:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              ack;
    logic [15:0]       rdata;

    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a 256Kx16 async SRAM; fixed-priority A with a B starvation guard,
// or round-robin when SRAM_ARB_ROUND_ROBIN_EN is defined. Latency: ack WAIT_CYCLES+2 cycles after grant.
// Backpressure: requests wait in IDLE; one access per WAIT_CYCLES+3 cycles, never granted during DONE.
module sram_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    sram_arbiter_if.slave     port_a,
    sram_arbiter_if.slave     port_b,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_d_out,
    output logic              sram_d_oe,
    input  logic [15:0]       sram_d_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              port_sel, port_nxt;
    logic              we_q, we_nxt;
    logic [1:0]        be_q, be_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       wdata_nxt;
    logic              grant_a, grant_b, pick_b;
    logic              en_nxt;
    logic              a_ack, b_ack;
    logic [15:0]       a_rdata, b_rdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_b;
    assign pick_b = port_b.req && (!port_a.req || !last_b);
`else
    logic [3:0] starve_cnt;
    assign pick_b = port_b.req && (!port_a.req || starve_cnt == 4'(STARVE_LIMIT));
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (port_a.req || port_b.req) begin
                    state_nxt = SETUP;
                    grant_b   = pick_b;
                    grant_a   = !pick_b;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt   = 4'(WAIT_CYCLES - 1);
            end
            STROBE: begin
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase

        // sram_addr and sram_d_out double as the latched request address and write data
        port_nxt  = port_sel;
        we_nxt    = we_q;
        be_nxt    = be_q;
        addr_nxt  = sram_addr;
        wdata_nxt = sram_d_out;
        if (grant_a) begin
            port_nxt  = 1'b0;
            we_nxt    = port_a.we;
            be_nxt    = port_a.be;
            addr_nxt  = port_a.addr;
            wdata_nxt = port_a.wdata;
        end else if (grant_b) begin
            port_nxt  = 1'b1;
            we_nxt    = port_b.we;
            be_nxt    = port_b.be;
            addr_nxt  = port_b.addr;
            wdata_nxt = port_b.wdata;
        end
        en_nxt = (state_nxt != IDLE) && (be_nxt != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            port_sel   <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            sram_addr  <= '0;
            sram_d_out <= 16'h0000;
            sram_d_oe  <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= 16'h0000;
            b_rdata    <= 16'h0000;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_b     <= 1'b1;
`else
            starve_cnt <= 4'd0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            port_sel   <= port_nxt;
            we_q       <= we_nxt;
            be_q       <= be_nxt;
            sram_addr  <= addr_nxt;
            sram_d_out <= wdata_nxt;
            // Strobes are registered from the next state so pins change cleanly on the edge
            sram_ce_n  <= !en_nxt;
            sram_lb_n  <= !(en_nxt && be_nxt[0]);
            sram_ub_n  <= !(en_nxt && be_nxt[1]);
            sram_oe_n  <= !(en_nxt && !we_nxt && state_nxt != DONE);
            sram_we_n  <= !(en_nxt && we_nxt && state_nxt == STROBE);
            sram_d_oe  <= en_nxt && we_nxt;
            a_ack      <= (state_nxt == DONE) && !port_nxt;
            b_ack      <= (state_nxt == DONE) && port_nxt;

            if (state == STROBE && cnt == 4'd0 && !we_q) begin
                if (port_sel) begin
                    if (be_q[0]) b_rdata[7:0]  <= sram_d_in[7:0];
                    if (be_q[1]) b_rdata[15:8] <= sram_d_in[15:8];
                end else begin
                    if (be_q[0]) a_rdata[7:0]  <= sram_d_in[7:0];
                    if (be_q[1]) a_rdata[15:8] <= sram_d_in[15:8];
                end
            end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (grant_a)      last_b <= 1'b0;
            else if (grant_b) last_b <= 1'b1;
`else
            if (state == IDLE) begin
                if (!port_b.req || grant_b) starve_cnt <= 4'd0;
                else if (grant_a)           starve_cnt <= starve_cnt + 4'd1;
            end
`endif
        end
    end

    assign busy         = (state != IDLE);
    assign port_a.ack   = a_ack;
    assign port_b.ack   = b_ack;
    assign port_a.rdata = a_rdata;
    assign port_b.rdata = b_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table of single-port accesses against an SRAM model, plus reset-abort,
// late-request and contention sequences. Acks are checked against a scoreboard of expected port/rdata.
module tb_sram_arbiter;
    localparam int ADDR_W = 18;
    localparam int WAIT   = 1;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_d_out, sram_d_in;
    logic              sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, busy;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W)) pa ();
    sram_arbiter_if #(.ADDR_W(ADDR_W)) pb ();

    sram_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .port_a(pa), .port_b(pb),
        .sram_addr(sram_addr), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .busy(busy)
    );

    // Async SRAM model, 1K words is enough for the addresses used here
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  <= sram_d_out[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_d_out[15:8];
        end
    end
    assign sram_d_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic [15:0] rdata;
    } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        if (!sram_we_n && !sram_oe_n) begin
            errors++;
            $display("FAIL we_oe_overlap we_n=%0b oe_n=%0b expected not both low", sram_we_n, sram_oe_n);
        end
        if (pa.ack && pb.ack) begin
            errors++;
            $display("FAIL dual_ack a_ack=1 b_ack=1 expected at most one");
        end else if (pa.ack || pb.ack) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack a_ack=%0b b_ack=%0b expected none", pa.ack, pb.ack);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("ack_port", 32'(pb.ack), 32'(e.port));
                chk("ack_rdata", 32'(pb.ack ? pb.rdata : pa.rdata), 32'(e.rdata));
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we, input logic [1:0] be,
                         input logic [9:0] addr, input logic [15:0] wdata);
        if (port) begin
            pb.req = req; pb.we = we; pb.be = be; pb.addr = {8'h00, addr}; pb.wdata = wdata;
        end else begin
            pa.req = req; pa.we = we; pa.be = be; pa.addr = {8'h00, addr}; pa.wdata = wdata;
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  be;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        pre;
        logic [15:0] pre_val;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int lat, ce, oe, we, lb, ub, doe;
        logic got;
        logic [ADDR_W-1:0] addr_at_ack;
        logic [15:0] dout_at_ack;
        lat = 0; ce = 0; oe = 0; we = 0; lb = 0; ub = 0; doe = 0; got = 1'b0;
        if (v.pre) mem[v.addr] = v.pre_val;
        sb.push_back('{v.port, v.exp_rdata});
        drive(v.port, 1'b1, v.we, v.be, v.addr, v.wdata);
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            ce  += int'(!sram_ce_n);
            oe  += int'(!sram_oe_n);
            we  += int'(!sram_we_n);
            lb  += int'(!sram_lb_n);
            ub  += int'(!sram_ub_n);
            doe += int'(sram_d_oe);
            got = v.port ? pb.ack : pa.ack;
        end
        addr_at_ack = sram_addr;
        dout_at_ack = sram_d_out;
        drive(v.port, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        chk("latency", 32'(lat), 32'(WAIT + 2));
        chk("ce_cycles", 32'(ce), 32'(v.be != 2'b00 ? WAIT + 2 : 0));
        chk("lb_cycles", 32'(lb), 32'(v.be[0] ? WAIT + 2 : 0));
        chk("ub_cycles", 32'(ub), 32'(v.be[1] ? WAIT + 2 : 0));
        chk("addr", 32'(addr_at_ack), 32'(v.addr));
        if (v.be != 2'b00) begin
            chk("we_cycles", 32'(we), 32'(v.we ? WAIT : 0));
            chk("oe_cycles", 32'(oe), 32'(v.we ? 0 : WAIT + 1));
            chk("doe_cycles", 32'(doe), 32'(v.we ? WAIT + 2 : 0));
        end
        if (v.we) chk("d_out", 32'(dout_at_ack), 32'(v.wdata));
        @(negedge clk);
    endtask

    initial begin
        int lat, acks;
        logic exp_port;

        //          port  we    be     addr    wdata     pre   pre_val   exp_rdata
        vecs[0] = '{1'b0, 1'b1, 2'b11, 10'h123, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 2'b11, 10'h123, 16'h0000, 1'b0, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 2'b11, 10'h055, 16'h0000, 1'b1, 16'hAAAA, 16'hAAAA};
        vecs[3] = '{1'b0, 1'b0, 2'b01, 10'h056, 16'h0000, 1'b1, 16'h1234, 16'hAA34};
        vecs[4] = '{1'b1, 1'b1, 2'b10, 10'h200, 16'h5A00, 1'b1, 16'h0011, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 10'h200, 16'h0000, 1'b0, 16'h0000, 16'h5A11};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 10'h200, 16'h0000, 1'b0, 16'h0000, 16'h5A11};
        vecs[7] = '{1'b1, 1'b1, 2'b00, 10'h201, 16'hFFFF, 1'b1, 16'h0707, 16'h5A11};
        vecs[8] = '{1'b1, 1'b0, 2'b11, 10'h201, 16'h0000, 1'b0, 16'h0000, 16'h0707};
        vecs[9] = '{1'b0, 1'b0, 2'b10, 10'h123, 16'h0000, 1'b0, 16'h0000, 16'hBE34};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
        chk("rst_d_oe", 32'(sram_d_oe), 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_d_out", 32'(sram_d_out), 32'h0);
        chk("rst_acks", 32'({pa.ack, pb.ack}), 32'h0);
        chk("rst_rdata", {pa.rdata, pb.rdata}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset during the STROBE cycle of a B write aborts it without an ack
        drive(1'b1, 1'b1, 1'b1, 2'b11, 10'h300, 16'h1111);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("abort_we_low", 32'(sram_we_n), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
        chk("abort_d_oe", 32'(sram_d_oe), 32'h0);
        chk("abort_b_ack", 32'(pb.ack), 32'h0);
        chk("abort_busy_clr", 32'(busy), 32'h0);
        chk("abort_rdata", {pa.rdata, pb.rdata}, 32'h0);
        reset = 1'b0;
        sb.push_back('{1'b1, 16'h0000});
        lat = 0;
        while (!pb.ack && lat < 20) begin @(negedge clk); lat++; end
        chk("regrant_latency", 32'(lat), 32'(WAIT + 2));
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        @(negedge clk);

        // B request rising during A's DONE waits for IDLE
        sb.push_back('{1'b0, 16'h0000});
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h010, 16'h0F0F);
        lat = 0;
        while (!pa.ack && lat < 20) begin @(negedge clk); lat++; end
        chk("late_a_latency", 32'(lat), 32'(WAIT + 2));
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        sb.push_back('{1'b1, 16'h0F0F});
        drive(1'b1, 1'b1, 1'b0, 2'b11, 10'h010, 16'h0000);
        lat = 0;
        while (!pb.ack && lat < 20) begin @(negedge clk); lat++; end
        chk("late_b_latency", 32'(lat), 32'(WAIT + 3));
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        @(negedge clk);

        // Both ports hold no-op requests; grant order comes from the scoreboard
        for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp_port = (i % 2) == 1;
`else
            exp_port = (i % (LIMIT + 1)) == LIMIT;
`endif
            sb.push_back('{exp_port, exp_port ? 16'h0F0F : 16'h0000});
        end
        drive(1'b0, 1'b1, 1'b0, 2'b00, 10'h020, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 10'h021, 16'h0000);
        acks = 0;
        lat = 0;
        while (acks < 10 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (pa.ack || pb.ack) acks++;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        chk("contend_acks", 32'(acks), 32'd10);
        repeat (8) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        chk("final_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
